// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: access sizes, FSM states,
// the captured request and the alignment check.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Only the fields still needed after accept; the word index lives in mem_addr.
    typedef struct packed {
        size_e       size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and memory-side signals of the load/store unit.
// slave is the LSU view; master is the pipeline/memory-environment view.
interface dmem_lsu_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Kept standalone so forwarding paths can reuse the same lane rules.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_off,
    input  size_e       ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  st_off,
    input  size_e       st_size,
    output logic [31:0] st_word
);
    logic [4:0]  ld_bsh, ld_hsh, st_bsh, st_hsh;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign ld_bsh = {ld_off, 3'b000};
    assign ld_hsh = {ld_off[1], 4'b0000};
    assign st_bsh = {st_off, 3'b000};
    assign st_hsh = {st_off[1], 4'b0000};
    assign ld_b   = ld_word[ld_bsh +: 8];
    assign ld_h   = ld_word[ld_hsh +: 16];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_b[7] & ~ld_unsigned}}, ld_b};
            SZ_H:    ld_data = {{16{ld_h[15] & ~ld_unsigned}}, ld_h};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (st_size)
            SZ_B:    st_word[st_bsh +: 8]  = st_wdata[7:0];
            SZ_H:    st_word[st_hsh +: 16] = st_wdata[15:0];
            default: st_word = st_wdata;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the single-port word-indexed data memory.
// Sub-word stores go through a read-modify-write since memory has only a word write enable.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 32
) (
    input logic        clk,
    input logic        rst,
    dmem_lsu_if.slave  bus
);
    state_e        state;
    req_t          req_q;
    size_e         req_size;
    logic [AW-1:0] idx;
    logic          req_err;
    logic          rsp_valid_q, rsp_err_q, mem_we_q;
    logic [31:0]   rsp_rdata_q, mem_wdata_q, ld_data, st_word;
    logic [AW-1:0] mem_addr_q;

    assign req_size = size_e'(bus.req_size);
    assign idx      = {2'b00, bus.req_addr[AW-1:2]};
    assign req_err  = (req_size == SZ_X) || is_misaligned(req_size, bus.req_addr[1:0]) ||
                      (idx >= AW'(DEPTH_WORDS));

    dmem_lsu_align u_align (
        .ld_word     (bus.mem_rdata),
        .ld_off      (req_q.off),
        .ld_size     (req_q.size),
        .ld_unsigned (req_q.uns),
        .ld_data     (ld_data),
        .st_old      (bus.mem_rdata),
        .st_wdata    (req_q.wdata),
        .st_off      (req_q.off),
        .st_size     (req_q.size),
        .st_word     (st_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    req_q     <= '{size: req_size, uns: bus.req_unsigned,
                                   off: bus.req_addr[1:0], wdata: bus.req_wdata};
                    rsp_err_q <= 1'b0;
                    if (req_err) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else if (!bus.req_we) begin
                        state      <= ST_LOAD;
                        mem_addr_q <= idx;
                    end else if (req_size == SZ_W) begin
                        state       <= ST_STORE;
                        mem_addr_q  <= idx;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= bus.req_wdata;
                    end else begin
                        state      <= ST_RMW_RD;
                        mem_addr_q <= idx;
                    end
                end
                ST_LOAD: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ld_data;
                end
                // The merged word is registered at the read edge, so the write
                // cycle drives memory straight from flops.
                ST_RMW_RD: begin
                    state       <= ST_RMW_WR;
                    mem_addr_q  <= mem_addr_q;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= st_word;
                end
                ST_STORE, ST_RMW_WR: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    // Gate with reset so a write in flight never lands on the reset edge.
    assign bus.mem_we    = mem_we_q & ~rst;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: word/sub-word loads and stores, errors,
// reset during read-modify-write and back-to-back requests.
module tb_dmem_lsu;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    int          checks, passes, fails;
    int          we_cnt;
    logic [31:0] mem [0:DEPTH-1];

    dmem_lsu_if #(.AW(32)) bus ();
    dmem_lsu #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_wr);
        int lat;
        int wr0;
        @(negedge clk);
        drive(we, size, uns, addr, wdata);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        wr0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, "_maddr"}, bus.mem_addr, exp_err ? 32'd0 : {2'b00, addr[31:2]});
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_wr"}, 32'(we_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        int wr0;
        int acc;
        int nrsp;
        logic was_ready;
        logic [31:0] b2b_addr [3];
        logic [1:0]  b2b_size [3];
        logic        b2b_uns  [3];
        logic [31:0] b2b_exp  [3];

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        do_req("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        chk("sw40_mem", mem[16], 32'hDEADBEEF);
        do_req("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        // Sub-word stores via RMW
        do_req("pre8", 1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, 2, 1'b0, 32'h0, 1);
        do_req("sb9", 1'b1, 2'd0, 1'b0, 32'h9, 32'h123456AA, 3, 1'b0, 32'h0, 1);
        chk("sb9_mem", mem[2], 32'h1122AA44);
        do_req("shA", 1'b1, 2'd1, 1'b0, 32'hA, 32'hCAFEBEEF, 3, 1'b0, 32'h0, 1);
        chk("shA_mem", mem[2], 32'hBEEFAA44);

        // Extraction and extension
        do_req("pre0", 1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01, 2, 1'b0, 32'h0, 1);
        do_req("lb3", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 2, 1'b0, 32'hFFFFFF80, 0);
        do_req("lbu3", 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 2, 1'b0, 32'h00000080, 0);
        do_req("lb1", 1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 2, 1'b0, 32'h0000007F, 0);
        do_req("lh2", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 2, 1'b0, 32'hFFFF80FF, 0);
        do_req("lhu0", 1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 2, 1'b0, 32'h00007F01, 0);
        do_req("lhuA", 1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 2, 1'b0, 32'h0000BEEF, 0);

        // Errors
        do_req("e_lh1", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("e_sw6", 1'b1, 2'd2, 1'b0, 32'h6, 32'h55, 1, 1'b1, 32'h0, 0);
        do_req("e_sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("e_lw1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("e_sb1000", 1'b1, 2'd0, 1'b0, 32'h1000, 32'h77, 1, 1'b1, 32'h0, 0);

        // Last legal word, and rsp_rdata holding between responses
        do_req("swFFC", 1'b1, 2'd2, 1'b0, 32'hFFC, 32'h5A5A0001, 2, 1'b0, 32'h0, 1);
        do_req("lwFFC", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 2, 1'b0, 32'h5A5A0001, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rdata", bus.rsp_rdata, 32'h5A5A0001);

        // Reset during RMW_RD
        do_req("pre4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h01020304, 2, 1'b0, 32'h0, 1);
        do_req("lw4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 2, 1'b0, 32'h01020304, 0);
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h4, 32'h000000FF);
        wr0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rrd_busy", 32'(bus.req_ready), 32'd0);
        chk("rrd_maddr", bus.mem_addr, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rrd_ready", 32'(bus.req_ready), 32'd1);
        chk("rrd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rrd_rdata", bus.rsp_rdata, 32'd0);
        chk("rrd_err", 32'(bus.rsp_err), 32'd0);
        chk("rrd_mem_addr", bus.mem_addr, 32'd0);
        chk("rrd_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rrd_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("rrd_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rrd_wr", 32'(we_cnt - wr0), 32'd0);
        chk("rrd_mem", mem[1], 32'h01020304);

        // Reset during RMW_WR: the write must be suppressed
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h4, 32'h000000FF);
        wr0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rwr_we_hi", 32'(bus.mem_we), 32'd1);
        chk("rwr_wdata", bus.mem_wdata, 32'h010203FF);
        rst = 1'b1;
        #1;
        chk("rwr_we_gated", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        chk("rwr_wr", 32'(we_cnt - wr0), 32'd0);
        chk("rwr_mem", mem[1], 32'h01020304);
        @(negedge clk);
        rst = 1'b0;

        // Three back-to-back loads with req_valid held high
        b2b_addr = '{32'h40, 32'h3, 32'hA};
        b2b_size = '{2'd2, 2'd0, 2'd1};
        b2b_uns  = '{1'b0, 1'b1, 1'b0};
        b2b_exp  = '{32'hDEADBEEF, 32'h00000080, 32'hFFFFBEEF};
        acc  = 0;
        nrsp = 0;
        @(negedge clk);
        drive(1'b0, b2b_size[0], b2b_uns[0], b2b_addr[0], 32'h0);
        for (int cyc = 0; cyc < 30 && nrsp < 3; cyc++) begin
            was_ready = bus.req_ready;
            @(posedge clk); #1;
            if (was_ready && bus.req_valid) begin
                acc++;
                if (acc < 3) drive(1'b0, b2b_size[acc], b2b_uns[acc], b2b_addr[acc], 32'h0);
                else bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                chk($sformatf("b2b_ready_low%0d", nrsp), 32'(bus.req_ready), 32'd0);
                chk($sformatf("b2b_data%0d", nrsp), bus.rsp_rdata, b2b_exp[nrsp]);
                nrsp++;
            end
        end
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_rsps", 32'(nrsp), 32'd3);
        chk("b2b_idle", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
